audio_dma_arbiter: RTL and testbench
====================================

# audio_dma_arbiter

Shares the single DMA sound-refill path between direct-sound channels A and B. It latches each channel's sound request and arbitrates round-robin when both are pending. It drives one request/grant handshake to the DMA engine, then counts the words of the burst until the refill completes. It sits between the two direct-sound units (sound requests, FIFO fill levels, FIFO clears) and the DMA controller, in the gba_clk domain.

## Interface
Parameters:
- BURST_WORDS, 4, 32-bit words delivered per granted refill
- FIFO_DEPTH, 8, FIFO capacity in words
- WDOG_CYCLES, 1024, idle-word timeout in XFER (used only with AUDIO_DMA_WDOG_EN)

Ports:
- clock  in  1  gba_clk domain; one clock
- reset  in  1  synchronous, active-high
- req_a / req_b  in  1  one-cycle sound request pulse from direct sound A / B
- fifo_size_a / fifo_size_b  in  4  current FIFO fill in words
- fifo_clr_a / fifo_clr_b  in  1  FIFO clear pulse; cancels that channel's pending request
- dma_req  out  1  refill request to DMA engine
- dma_sel  out  1  channel being requested/served (0=A, 1=B)
- dma_grant  in  1  one-cycle accept pulse from DMA; valid only while dma_req=1
- word_wr  in  1  one pulse per word written into the selected FIFO
- busy  out  1  high in REQ, XFER or DONE
- served_a / served_b  out  1  one-cycle completion pulse
- wdog_err  out  1  sticky timeout flag (tied 0 without AUDIO_DMA_WDOG_EN)

## Operation
- Pending flags pend_a and pend_b:
  - set on req_x.
  - cleared on fifo_clr_x, on the DONE of channel x, or when channel x is dropped by the full guard.
  - Clear wins over a simultaneous req.
- A req_x for the channel currently in XFER or DONE is ignored; a req for the other channel latches normally.
- Round-robin pointer last: after reset it is B, so A wins the first tie. It updates to the served channel in DONE only.
- State machine:
  - IDLE: if any flag is pending, choose the candidate (the only pending channel, or the channel other than last on a tie).
    - Full guard: if the candidate's fifo_size > FIFO_DEPTH−BURST_WORDS, clear its flag and stay in IDLE.
    - Otherwise latch dma_sel and go to REQ.
  - REQ: dma_req=1.
    - dma_grant goes to XFER with the word count at 0.
    - fifo_clr for the selected channel (without a grant in the same cycle) clears the flag and returns to IDLE.
    - Grant and clear in the same cycle: the grant wins, go to XFER, and the flag is cleared.
  - XFER: count word_wr pulses. On the BURST_WORDS-th word go to DONE.
    - fifo_clr in XFER clears the flag but does not abort; the burst must finish.
  - DONE: one cycle. Pulse served_x, clear pend_x, update last, go to IDLE.
- word_wr outside XFER is ignored. The word counter is 3 bits wide and saturates at BURST_WORDS.
- Outputs after reset: dma_req=0, dma_sel=0, busy=0, served_a=0, served_b=0, wdog_err=0, state IDLE, pend_a=pend_b=0.

## Timing
- req_x pulse at cycle t: pend_x=1 at t+1, state REQ and dma_req=1 at t+2, provided the arbiter is idle and the guard passes.
- dma_grant at cycle g: dma_req=0 and state XFER at g+1.
- Last word_wr at cycle w: served_x=1 and busy=1 at w+1 (DONE), IDLE at w+2.
- Another pending channel enters REQ at w+3.
- Minimum request-to-request spacing: 3 cycles after the final word.
- dma_sel is stable from entry to REQ until exit from DONE.
- Reset mid-operation: all state returns to IDLE at the next edge and dma_req drops immediately. The DMA engine is responsible for discarding the burst.

## Configuration
- AUDIO_DMA_WDOG_EN defined:
  - A 10-bit idle counter runs in XFER and reloads on every word_wr.
  - If WDOG_CYCLES cycles pass without a word: set wdog_err (sticky until reset), go to DONE without a served pulse, clear pend_x, update last.
- AUDIO_DMA_WDOG_EN undefined:
  - No counter is built and wdog_err is tied 0.
  - XFER waits indefinitely for words.

## Test plan
- Single channel: req_a at t=10, fifo_size_a=2, grant at t=14, 4 word_wr at t=15..18 -> dma_req high at t=12..14, dma_sel=0, served_a at t=19, busy low at t=20.
- Tie: req_a and req_b in the same cycle after reset -> A served first, B enters REQ 3 cycles after A's last word with dma_sel=1, then served_b.
- Full guard: req_b with fifo_size_b=5 -> no dma_req, pend_b cleared at next cycle, busy stays 0.
- Cancel: req_a, then fifo_clr_a while in REQ with no grant -> dma_req drops next cycle, no served_a. Repeat with clr during XFER -> burst completes, served_a pulses.
- Re-request: req_a during A's XFER -> ignored, only one burst. req_b during A's XFER -> B served afterwards.
- Watchdog (macro on, WDOG_CYCLES=16): grant, then 2 words, then silence -> wdog_err=1 after 16 idle cycles, no served_a, state returns to IDLE. Macro off: arbiter stays in XFER and wdog_err=0.

Source files
------------

// File: rtl/audio_dma_arbiter.sv
// audio_dma_arbiter: round-robin owner of the single DMA sound-refill path for direct-sound A and B.
// Optional XFER idle-word watchdog is built when AUDIO_DMA_WDOG_EN is defined.
module audio_dma_arbiter #(
    parameter int BURST_WORDS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] fifo_size_a,
    input  logic [3:0] fifo_size_b,
    input  logic       fifo_clr_a,
    input  logic       fifo_clr_b,
    output logic       dma_req,
    output logic       dma_sel,
    input  logic       dma_grant,
    input  logic       word_wr,
    output logic       busy,
    output logic       served_a,
    output logic       served_b,
    output logic       wdog_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    localparam logic [2:0] BURST_CNT  = 3'(BURST_WORDS);
    localparam logic [2:0] LAST_WORD  = 3'(BURST_WORDS - 1);
    localparam logic [4:0] FILL_LIMIT = 5'(FIFO_DEPTH - BURST_WORDS);

    state_t     state;
    logic       pend_a;
    logic       pend_b;
    logic       last;
    logic [2:0] word_cnt;

    logic       cand;
    logic       cand_valid;
    logic       cand_full;
    logic       set_a;
    logic       set_b;
    logic       clr_a;
    logic       clr_b;
    logic       sel_clr;
    logic       timeout;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        cand_valid = pend_a | pend_b;
        cand       = (pend_a & pend_b) ? ~last : pend_b;
        cand_full  = cand ? ({1'b0, fifo_size_b} > FILL_LIMIT)
                          : ({1'b0, fifo_size_a} > FILL_LIMIT);
        sel_clr    = dma_sel ? fifo_clr_b : fifo_clr_a;

        // The channel owning XFER/DONE may not re-arm itself until the burst retires.
        set_a = req_a & ~((state == XFER || state == DONE) && !dma_sel);
        set_b = req_b & ~((state == XFER || state == DONE) &&  dma_sel);

        clr_a = fifo_clr_a
              | (state == DONE && !dma_sel)
              | (state == IDLE && cand_valid && cand_full && !cand);
        clr_b = fifo_clr_b
              | (state == DONE &&  dma_sel)
              | (state == IDLE && cand_valid && cand_full &&  cand);
    end

`ifdef AUDIO_DMA_WDOG_EN
    localparam logic [9:0] IDLE_LAST = 10'(WDOG_CYCLES - 1);

    logic [9:0] idle_cnt;

    assign timeout = (state == XFER) && !word_wr && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state != XFER || word_wr) idle_cnt <= '0;
            else                          idle_cnt <= idle_cnt + 10'd1;
            if (timeout) wdog_err <= 1'b1;
        end
    end
`else
    logic wdog_cycles_unused;

    assign wdog_cycles_unused = (WDOG_CYCLES == 0);
    assign timeout            = 1'b0;
    assign wdog_err           = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            last     <= 1'b1;
            word_cnt <= '0;
            dma_req  <= 1'b0;
            dma_sel  <= 1'b0;
            busy     <= 1'b0;
            served_a <= 1'b0;
            served_b <= 1'b0;
        end else begin
            pend_a   <= ~clr_a & (set_a | pend_a);
            pend_b   <= ~clr_b & (set_b | pend_b);
            served_a <= 1'b0;
            served_b <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cand_valid && !cand_full) begin
                        state   <= REQ;
                        dma_sel <= cand;
                        dma_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (dma_grant) begin
                        state    <= XFER;
                        dma_req  <= 1'b0;
                        word_cnt <= '0;
                    end else if (sel_clr) begin
                        state   <= IDLE;
                        dma_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                XFER: begin
                    if (word_wr) begin
                        if (word_cnt != BURST_CNT) word_cnt <= word_cnt + 3'd1;
                        if (word_cnt == LAST_WORD) begin
                            state    <= DONE;
                            served_a <= ~dma_sel;
                            served_b <=  dma_sel;
                        end
                    end else if (timeout) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    last  <= dma_sel;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// Self-checking bench for audio_dma_arbiter: directed scenario tasks plus a randomized run
// against a transaction-style reference model (owner / granted / words-received view).
module tb_audio_dma_arbiter;

    localparam int BURST = 4;
    localparam int DEPTH = 8;
    localparam int WDOG  = 16;

    logic       clock;
    logic       reset;
    logic       req_a, req_b;
    logic [3:0] fifo_size_a, fifo_size_b;
    logic       fifo_clr_a, fifo_clr_b;
    logic       dma_req, dma_sel, dma_grant, word_wr;
    logic       busy, served_a, served_b, wdog_err;

    int n_checks = 0;
    int n_pass   = 0;

    audio_dma_arbiter #(
        .BURST_WORDS(BURST),
        .FIFO_DEPTH (DEPTH),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_a      (req_a),
        .req_b      (req_b),
        .fifo_size_a(fifo_size_a),
        .fifo_size_b(fifo_size_b),
        .fifo_clr_a (fifo_clr_a),
        .fifo_clr_b (fifo_clr_b),
        .dma_req    (dma_req),
        .dma_sel    (dma_sel),
        .dma_grant  (dma_grant),
        .word_wr    (word_wr),
        .busy       (busy),
        .served_a   (served_a),
        .served_b   (served_b),
        .wdog_err   (wdog_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL time_limit bench did not finish: got timeout, need completion");
        $fatal(1, "time limit");
    end

    // Reference model state: who owns the path, whether the DMA accepted, words seen so far.
    int m_owner;
    bit m_granted;
    int m_words;
    int m_idle;
    bit m_timed_out;
    bit m_pend[2];
    bit m_last;
    bit m_sel;
    bit m_wdog;

    task automatic model_init();
        m_owner = -1; m_granted = 0; m_words = 0; m_idle = 0; m_timed_out = 0;
        m_pend[0] = 0; m_pend[1] = 0; m_last = 1; m_sel = 0; m_wdog = 0;
    endtask

    task automatic model_step(input bit rq0, input bit rq1, input bit cl0, input bit cl1,
                              input int sz0, input int sz1, input bit g, input bit wr);
        bit rq[2]; bit cl[2]; int sz[2]; bit drop[2]; bit fin[2]; bit own[2];
        rq[0] = rq0; rq[1] = rq1; cl[0] = cl0; cl[1] = cl1; sz[0] = sz0; sz[1] = sz1;
        for (int x = 0; x < 2; x++) begin
            drop[x] = 0; fin[x] = 0;
            own[x]  = (m_owner == x) && m_granted;
        end
        if (m_owner < 0) begin
            if (m_pend[0] || m_pend[1]) begin
                int c;
                c = (m_pend[0] && m_pend[1]) ? (m_last ? 0 : 1) : (m_pend[0] ? 0 : 1);
                if (sz[c] > DEPTH - BURST) drop[c] = 1;
                else begin
                    m_owner = c; m_sel = (c == 1); m_granted = 0;
                    m_words = 0; m_idle = 0; m_timed_out = 0;
                end
            end
        end else if (!m_granted) begin
            if (g) m_granted = 1;
            else if (cl[m_owner]) m_owner = -1;
        end else if (m_words < BURST) begin
            if (wr) begin
                m_words++; m_idle = 0;
            end else begin
                m_idle++;
`ifdef AUDIO_DMA_WDOG_EN
                if (m_idle == WDOG) begin
                    m_words = BURST; m_timed_out = 1; m_wdog = 1;
                end
`endif
            end
        end else begin
            fin[m_owner] = 1; m_last = (m_owner == 1); m_owner = -1;
        end
        for (int x = 0; x < 2; x++)
            m_pend[x] = !(cl[x] || fin[x] || drop[x]) && (m_pend[x] || (rq[x] && !own[x]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 0; req_b = 0; fifo_clr_a = 0; fifo_clr_b = 0;
        fifo_size_a = 0; fifo_size_b = 0; dma_grant = 0; word_wr = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({dma_req, dma_sel, busy, served_a, served_b, wdog_err} !== 6'b0)
            $display("FAIL reset_state got=%b need=000000", {dma_req, dma_sel, busy, served_a, served_b, wdog_err});
        else n_pass++;
        fifo_size_b = 4'd1; req_b = 1; @(negedge clock); req_b = 0;
        @(negedge clock);
        n_checks++; if ({dma_req, dma_sel} !== 2'b11) $display("FAIL midop_req got=%b need=11", {dma_req, dma_sel}); else n_pass++;
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        n_checks++; if ({dma_req, dma_sel, busy} !== 3'b000) $display("FAIL midop_reset got=%b need=000", {dma_req, dma_sel, busy}); else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++; if (dma_req !== 1'b0) $display("FAIL midop_pend_cleared dma_req=%b need=0", dma_req); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        fifo_size_a = 4'd2; req_a = 1; @(negedge clock); req_a = 0;   // t=11
        n_checks++; if (dma_req !== 1'b0) $display("FAIL single_t11 dma_req=%b need=0", dma_req); else n_pass++;
        @(negedge clock);                                             // t=12
        n_checks++; if ({dma_req, dma_sel, busy} !== 3'b101) $display("FAIL single_t12 req/sel/busy=%b need=101", {dma_req, dma_sel, busy}); else n_pass++;
        @(negedge clock);                                             // t=13
        @(negedge clock);                                             // t=14
        n_checks++; if (dma_req !== 1'b1) $display("FAIL single_t14 dma_req=%b need=1", dma_req); else n_pass++;
        dma_grant = 1; @(negedge clock); dma_grant = 0;               // t=15
        n_checks++; if ({dma_req, busy} !== 2'b01) $display("FAIL single_t15 req/busy=%b need=01", {dma_req, busy}); else n_pass++;
        word_wr = 1; repeat (4) @(negedge clock); word_wr = 0;        // t=19
        n_checks++; if ({served_a, served_b, busy} !== 3'b101) $display("FAIL single_t19 sa/sb/busy=%b need=101", {served_a, served_b, busy}); else n_pass++;
        @(negedge clock);                                             // t=20
        n_checks++; if ({served_a, busy} !== 2'b00) $display("FAIL single_t20 sa/busy=%b need=00", {served_a, busy}); else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        req_a = 1; req_b = 1; @(negedge clock); req_a = 0; req_b = 0;
        @(negedge clock);
        n_checks++; if ({dma_req, dma_sel} !== 2'b10) $display("FAIL tie_first req/sel=%b need=10", {dma_req, dma_sel}); else n_pass++;
        dma_grant = 1; @(negedge clock); dma_grant = 0;
        word_wr = 1; repeat (4) @(negedge clock); word_wr = 0;
        n_checks++; if ({served_a, served_b} !== 2'b10) $display("FAIL tie_served_a sa/sb=%b need=10", {served_a, served_b}); else n_pass++;
        @(negedge clock);
        n_checks++; if ({dma_req, busy} !== 2'b00) $display("FAIL tie_gap req/busy=%b need=00", {dma_req, busy}); else n_pass++;
        @(negedge clock);
        n_checks++; if ({dma_req, dma_sel} !== 2'b11) $display("FAIL tie_second req/sel=%b need=11", {dma_req, dma_sel}); else n_pass++;
        dma_grant = 1; @(negedge clock); dma_grant = 0;
        word_wr = 1; repeat (4) @(negedge clock); word_wr = 0;
        n_checks++; if ({served_a, served_b, dma_sel} !== 3'b011) $display("FAIL tie_served_b sa/sb/sel=%b need=011", {served_a, served_b, dma_sel}); else n_pass++;
    endtask

    task automatic test_full_guard();
        int bad;
        do_reset();
        bad = 0;
        fifo_size_b = 4'd5; req_b = 1; @(negedge clock); req_b = 0;
        repeat (4) begin
            @(negedge clock);
            if (dma_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL guard_drop bad_cycles=%0d need=0", bad); else n_pass++;
        fifo_size_b = 4'd0; bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (dma_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL guard_flag_cleared bad_cycles=%0d need=0", bad); else n_pass++;
        fifo_size_b = 4'd4; req_b = 1; @(negedge clock); req_b = 0;
        @(negedge clock);
        n_checks++; if ({dma_req, dma_sel} !== 2'b11) $display("FAIL guard_boundary4 req/sel=%b need=11", {dma_req, dma_sel}); else n_pass++;
    endtask

    task automatic test_cancel();
        int bad;
        do_reset();
        req_a = 1; @(negedge clock); req_a = 0;
        @(negedge clock);
        fifo_clr_a = 1; @(negedge clock); fifo_clr_a = 0;
        n_checks++; if ({dma_req, busy} !== 2'b00) $display("FAIL cancel_req req/busy=%b need=00", {dma_req, busy}); else n_pass++;
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (dma_req !== 1'b0 || served_a !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL cancel_req_quiet bad_cycles=%0d need=0", bad); else n_pass++;

        req_a = 1; @(negedge clock); req_a = 0;
        @(negedge clock);
        dma_grant = 1; @(negedge clock); dma_grant = 0;
        word_wr = 1; fifo_clr_a = 1; @(negedge clock); fifo_clr_a = 0;
        repeat (3) @(negedge clock); word_wr = 0;
        n_checks++; if (served_a !== 1'b1) $display("FAIL cancel_xfer_served served_a=%b need=1", served_a); else n_pass++;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (dma_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL cancel_xfer_no_rereq bad_cycles=%0d need=0", bad); else n_pass++;
    endtask

    task automatic test_rerequest();
        int bad;
        do_reset();
        req_a = 1; @(negedge clock); req_a = 0;
        @(negedge clock);
        dma_grant = 1; @(negedge clock); dma_grant = 0;
        word_wr = 1; req_a = 1; @(negedge clock); req_a = 0;
        repeat (3) @(negedge clock); word_wr = 0;
        n_checks++; if (served_a !== 1'b1) $display("FAIL rereq_a_served served_a=%b need=1", served_a); else n_pass++;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (dma_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rereq_a_ignored bad_cycles=%0d need=0", bad); else n_pass++;

        req_a = 1; @(negedge clock); req_a = 0;
        @(negedge clock);
        dma_grant = 1; @(negedge clock); dma_grant = 0;
        word_wr = 1; @(negedge clock); req_b = 1; @(negedge clock); req_b = 0;
        repeat (2) @(negedge clock); word_wr = 0;
        n_checks++; if ({served_a, served_b} !== 2'b10) $display("FAIL rereq_b_first sa/sb=%b need=10", {served_a, served_b}); else n_pass++;
        repeat (2) @(negedge clock);
        n_checks++; if ({dma_req, dma_sel} !== 2'b11) $display("FAIL rereq_b_latched req/sel=%b need=11", {dma_req, dma_sel}); else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset();
        req_a = 1; @(negedge clock); req_a = 0;
        @(negedge clock);
        dma_grant = 1; @(negedge clock); dma_grant = 0;              // g+1
        word_wr = 1; repeat (2) @(negedge clock); word_wr = 0;      // g+3
`ifdef AUDIO_DMA_WDOG_EN
        repeat (15) @(negedge clock);                                // g+18
        n_checks++; if ({wdog_err, busy} !== 2'b01) $display("FAIL wdog_before err/busy=%b need=01", {wdog_err, busy}); else n_pass++;
        @(negedge clock);                                            // g+19
        n_checks++; if ({wdog_err, served_a, busy} !== 3'b101) $display("FAIL wdog_fire err/sa/busy=%b need=101", {wdog_err, served_a, busy}); else n_pass++;
        @(negedge clock);
        n_checks++; if ({wdog_err, busy} !== 2'b10) $display("FAIL wdog_idle err/busy=%b need=10", {wdog_err, busy}); else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++; if ({wdog_err, dma_req} !== 2'b10) $display("FAIL wdog_sticky err/req=%b need=10", {wdog_err, dma_req}); else n_pass++;
`else
        repeat (40) @(negedge clock);
        n_checks++; if ({wdog_err, busy, dma_req} !== 3'b010) $display("FAIL nowdog_wait err/busy/req=%b need=010", {wdog_err, busy, dma_req}); else n_pass++;
        word_wr = 1; repeat (2) @(negedge clock); word_wr = 0;
        n_checks++; if ({served_a, wdog_err} !== 2'b10) $display("FAIL nowdog_finish sa/err=%b need=10", {served_a, wdog_err}); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [5:0] act, exp;
        bit e_req;
        int shown;
        do_reset();
        model_init();
        shown = 0;
        for (int i = 0; i < 3000; i++) begin
            e_req = (m_owner >= 0) && !m_granted;
            exp = {e_req, m_sel, (m_owner >= 0),
                   (m_owner == 0) && m_granted && (m_words == BURST) && !m_timed_out,
                   (m_owner == 1) && m_granted && (m_words == BURST) && !m_timed_out,
                   m_wdog};
            act = {dma_req, dma_sel, busy, served_a, served_b, wdog_err};
            n_checks++;
            if (act !== exp) begin
                if (shown < 20) $display("FAIL random_cycle%0d req/sel/busy/sa/sb/err got=%b need=%b", i, act, exp);
                shown++;
            end else n_pass++;
            req_a       = ($urandom_range(0, 7) == 0);
            req_b       = ($urandom_range(0, 7) == 0);
            fifo_clr_a  = ($urandom_range(0, 39) == 0);
            fifo_clr_b  = ($urandom_range(0, 39) == 0);
            fifo_size_a = 4'($urandom_range(0, 6));
            fifo_size_b = 4'($urandom_range(0, 6));
            dma_grant   = e_req && ($urandom_range(0, 2) == 0);
            word_wr     = 1'($urandom_range(0, 1));
            model_step(req_a, req_b, fifo_clr_a, fifo_clr_b,
                       int'(fifo_size_a), int'(fifo_size_b), dma_grant, word_wr);
            @(negedge clock);
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_single();
        test_tie();
        test_full_guard();
        test_cancel();
        test_rerequest();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
